// File: rtl/aes_inv_cipher_pkg.sv
// Shared AES types and GF(2^8) helpers for the iterative AES-128 decryption core.
// The S-boxes are expressed as GF inverse plus affine map so synthesis flattens them to LUTs.
package aes_inv_cipher_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;

  // Bit offset of the byte at (row, col); column c holds bytes 4c..4c+3.
  function automatic int boff(input int row, input int col);
    return 8 * (4 * col + row);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = gf_mul2(t);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] r;
    t = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // Byte 1 of the word moves to byte 0.
  function automatic word_t rot_word(input word_t w);
    return {w[7:0], w[31:8]};
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Circulant row {0e,0b,0d,09}; idx is (input row - output row) mod 4.
  function automatic logic [7:0] inv_mix_coef(input int idx);
    logic [7:0] m;
    case (idx)
      0:       m = 8'h0e;
      1:       m = 8'h0b;
      2:       m = 8'h0d;
      default: m = 8'h09;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/aes_inv_cipher_round.sv
// One inverse AES round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless this is the final round.
module aes_inv_cipher_round
  import aes_inv_cipher_pkg::*;
(
  input  state_t i_state,
  input  state_t i_rk,
  input  logic   i_last_round,
  output state_t o_state
);

  state_t     w_ark;
  state_t     w_mix;
  logic [7:0] w_acc;

  // Shift/substitute/add key, then mix each column.
  always_comb begin
    w_ark = '0;
    w_mix = '0;
    w_acc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_ark[boff(r, c) +: 8] = inv_sbox(i_state[boff(r, (c + 4 - r) % 4) +: 8])
                                 ^ i_rk[boff(r, c) +: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_acc = '0;
        for (int k = 0; k < 4; k++) begin
          w_acc = w_acc ^ gf_mul(inv_mix_coef((k - r + 4) % 4), w_ark[boff(k, c) +: 8]);
        end
        w_mix[boff(r, c) +: 8] = w_acc;
      end
    end
  end

  assign o_state = i_last_round ? w_ark : w_mix;

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryption: expands the key forward to round key 10, then runs one inverse
// round per clock while regenerating round keys backwards through a shared SubWord unit.
module aes_inv_cipher
  import aes_inv_cipher_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [127:0] key,
  input  logic [127:0] cyphertext,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_INIT   = 2'd2;
  localparam logic [1:0] ST_DEC    = 2'd3;

  localparam logic [3:0] RND_LAST = 4'(NR);

  logic [1:0] r_state;
  logic [3:0] r_rnd;
  state_t     r_kreg;
  state_t     r_sreg;
  state_t     r_pt;
  logic       r_busy;
  logic       r_done;

  word_t      w_w0, w_w1, w_w2, w_w3;
  word_t      w_sw_in;
  word_t      w_g;
  word_t      w_f0, w_f1, w_f2, w_f3;
  logic [3:0] w_rcon_idx;
  state_t     w_kfwd;
  state_t     w_kinv;
  state_t     w_round_out;

  assign {w_w3, w_w2, w_w1, w_w0} = r_kreg;

  // EXPAND feeds w3 with rcon[rnd]; DEC feeds w3^w2 (the recovered w3) with rcon[rnd+1].
  assign w_sw_in    = (r_state == ST_DEC) ? (w_w3 ^ w_w2) : w_w3;
  assign w_rcon_idx = (r_state == ST_DEC) ? (r_rnd + 4'd1) : r_rnd;
  assign w_g        = sub_word(rot_word(w_sw_in)) ^ {24'h0, rcon(w_rcon_idx)};

  assign w_f0   = w_w0 ^ w_g;
  assign w_f1   = w_w1 ^ w_f0;
  assign w_f2   = w_w2 ^ w_f1;
  assign w_f3   = w_w3 ^ w_f2;
  assign w_kfwd = {w_f3, w_f2, w_f1, w_f0};
  assign w_kinv = {w_w3 ^ w_w2, w_w2 ^ w_w1, w_w1 ^ w_w0, w_w0 ^ w_g};

  aes_inv_cipher_round u_round (
    .i_state      (r_sreg),
    .i_rk         (w_kinv),
    .i_last_round (r_rnd == 4'd0),
    .o_state      (w_round_out)
  );

  // Control FSM, round counter and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_rnd   <= 4'd0;
      r_kreg  <= '0;
      r_sreg  <= '0;
      r_pt    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_kreg  <= key;
            r_sreg  <= cyphertext;
            r_rnd   <= 4'd1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          r_kreg <= w_kfwd;
          r_rnd  <= r_rnd + 4'd1;
          if (r_rnd == RND_LAST) r_state <= ST_INIT;
        end
        ST_INIT: begin
          r_sreg  <= r_sreg ^ r_kreg;
          r_rnd   <= RND_LAST - 4'd1;
          r_state <= ST_DEC;
        end
        default: begin
          r_kreg <= w_kinv;
          if (r_rnd == 4'd0) begin
            r_pt    <= w_round_out;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_sreg <= w_round_out;
            r_rnd  <= r_rnd - 4'd1;
          end
        end
      endcase
    end
  end

  assign plaintext = r_pt;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Scoreboard bench for aes_inv_cipher: stimulus pushes expected plaintext and due edge, a
// monitor pops on each rising done and compares against a byte-level AES reference model.
module tb_aes_inv_cipher;

  logic         clk;
  logic         reset_n;
  logic         load;
  logic [127:0] key;
  logic [127:0] cyphertext;
  logic [127:0] plaintext;
  logic         busy;
  logic         done;

  aes_inv_cipher dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .key        (key),
    .cyphertext (cyphertext),
    .plaintext  (plaintext),
    .busy       (busy),
    .done       (done)
  );

  localparam logic [127:0] K_C1  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] CT_C1 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] PT_C1 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] K_B   = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] CT_B  = 128'h320b6a19978511dcfb09dc021d842539;
  localparam logic [127:0] PT_B  = 128'h340737e0a29831318d305a88a8f64332;

  typedef struct {
    logic [127:0] pt;
    int           due;
    string        name;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         edge_cnt = 0;
  logic       done_prev = 1'b0;
  logic [7:0] sbt[256];
  logic [7:0] isbt[256];
  logic [7:0] rk_m[176];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box via walking generator 3 and its inverse in lockstep.
  task automatic build_tables();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sbt[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbt[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbt[sbt[i]] = 8'(i);
  endtask

  task automatic expand_key(input logic [127:0] k);
    logic [7:0] t[4];
    logic [7:0] tmp;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) rk_m[i] = k[8*i +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = rk_m[4*(i-1) + j];
      if (i % 4 == 0) begin
        tmp  = t[0];
        t[0] = sbt[t[1]] ^ rc;
        t[1] = sbt[t[2]];
        t[2] = sbt[t[3]];
        t[3] = sbt[tmp];
        rc   = xt(rc);
      end
      for (int j = 0; j < 4; j++) rk_m[4*i + j] = rk_m[4*(i-4) + j] ^ t[j];
    end
  endtask

  task automatic ref_decrypt(input logic [127:0] k, input logic [127:0] ct,
                             output logic [127:0] pt);
    logic [7:0] s[4][4];
    logic [7:0] t[4][4];
    expand_key(k);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = ct[8*(4*c+r) +: 8] ^ rk_m[160 + 4*c + r];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = isbt[s[r][(c+4-r)%4]] ^ rk_m[16*rnd + 4*c + r];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = (rnd == 0) ? t[r][c] :
                    gm(8'h0e, t[r][c]) ^ gm(8'h0b, t[(r+1)%4][c]) ^
                    gm(8'h0d, t[(r+2)%4][c]) ^ gm(8'h09, t[(r+3)%4][c]);
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) pt[8*(4*c+r) +: 8] = s[r][c];
  endtask

  task automatic ref_encrypt(input logic [127:0] k, input logic [127:0] pt,
                             output logic [127:0] ct);
    logic [7:0] s[4][4];
    logic [7:0] t[4][4];
    expand_key(k);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = pt[8*(4*c+r) +: 8] ^ rk_m[4*c + r];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r][c] = sbt[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r][c] = ((rnd == 10) ? t[r][c] :
                     gm(8'h02, t[r][c]) ^ gm(8'h03, t[(r+1)%4][c]) ^
                     t[(r+2)%4][c] ^ t[(r+3)%4][c]) ^ rk_m[16*rnd + 4*c + r];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) ct[8*(4*c+r) +: 8] = s[r][c];
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && done && !done_prev) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at edge %0d expected no result", edge_cnt);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_pt"}, plaintext, e.pt);
        check({e.name, "_latency"}, 128'(edge_cnt), 128'(e.due));
        check({e.name, "_busy_at_done"}, 128'(busy), 128'(0));
      end
    end
    done_prev = done;
  end

  // ---------------- stimulus ----------------
  task automatic start(input logic [127:0] k, input logic [127:0] c, input logic [127:0] e,
                       input string nm, input bit chk_hold, input logic [127:0] hold_v);
    exp_t x;
    @(negedge clk);
    load       = 1'b1;
    key        = k;
    cyphertext = c;
    @(posedge clk);
    #1;
    load   = 1'b0;
    x.pt   = e;
    x.due  = edge_cnt + 21;
    x.name = nm;
    sb_q.push_back(x);
    check({nm, "_busy_start"}, 128'(busy), 128'(1));
    check({nm, "_done_start"}, 128'(done), 128'(0));
    if (chk_hold) check({nm, "_pt_hold"}, plaintext, hold_v);
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_timeout: got %0d pending results expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    logic [127:0] rk;
    logic [127:0] rc;
    logic [127:0] rp;
    logic [127:0] last_pt;
    int           l_edge;
    exp_t         x;

    build_tables();
    reset_n    = 1'b0;
    load       = 1'b0;
    key        = '0;
    cyphertext = '0;
    #3;
    check("reset_pt", plaintext, '0);
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // C.1 with an ignored load pulse on edge 5.
    start(K_C1, CT_C1, PT_C1, "c1", 1'b0, '0);
    repeat (5) @(negedge clk);
    load       = 1'b1;
    key        = K_B;
    cyphertext = CT_B;
    @(posedge clk);
    #1;
    load = 1'b0;
    check("ignored_load_busy", 128'(busy), 128'(1));
    wait_empty(40);
    repeat (3) @(negedge clk);
    check("c1_idle_pt", plaintext, PT_C1);
    check("c1_idle_done", 128'(done), 128'(1));

    // Back-to-back: B while done=1, old plaintext must hold.
    start(K_B, CT_B, PT_B, "b_b2b", 1'b1, PT_C1);
    wait_empty(40);

    // Abort mid-run with reset on edge 15.
    start(K_C1, CT_C1, PT_C1, "abort", 1'b0, '0);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    check("abort_pt", plaintext, '0);
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_done", 128'(done), 128'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    start(K_B, CT_B, PT_B, "b_after_reset", 1'b1, '0);
    wait_empty(40);

    // Load held high: second run starts on the edge after the result edge.
    @(negedge clk);
    load       = 1'b1;
    key        = K_C1;
    cyphertext = CT_C1;
    @(posedge clk);
    #1;
    l_edge = edge_cnt;
    x.pt   = PT_C1;
    x.due  = l_edge + 21;
    x.name = "held1";
    sb_q.push_back(x);
    x.due  = l_edge + 43;
    x.name = "held2";
    sb_q.push_back(x);
    repeat (22) begin
      @(posedge clk);
      #1;
    end
    load = 1'b0;
    check("held_restart_busy", 128'(busy), 128'(1));
    check("held_restart_done", 128'(done), 128'(0));
    wait_empty(40);

    // Randomized: alternate model-decrypted ciphertexts and encrypt-then-decrypt round trips.
    last_pt = PT_C1;
    for (int i = 0; i < 1000; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      if (i % 2 == 1) begin
        rp = {$urandom, $urandom, $urandom, $urandom};
        ref_encrypt(rk, rp, rc);
      end else begin
        rc = {$urandom, $urandom, $urandom, $urandom};
        ref_decrypt(rk, rc, rp);
      end
      start(rk, rc, rp, $sformatf("rand%0d", i), (i % 50 == 0), last_pt);
      wait_empty(40);
      last_pt = rp;
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
